// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared loader state encoding, error codes and word width
package pipeline_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  // States in which the loader is still consuming frame bytes
  function automatic logic is_loading(state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - packs bytes MSB-first into words and strobes each completed word
module byte_word_assembler
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_last,
  output logic              we,
  output logic [WORD_W-1:0] word
);

  logic [1:0] idx;

  assign word_last = byte_valid && (idx == 2'd3);

  // The shift register still holds the finished word during the strobe cycle;
  // a byte accepted in that cycle only lands at the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= 2'd0;
      we   <= 1'b0;
      word <= '0;
    end else begin
      we <= word_last;
      if (byte_valid) begin
        word <= {word[WORD_W-9:0], byte_data};
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction memory writer, holds CPU in reset until verified
module program_loader
  import pipeline_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        In_Valid,
  input  logic [7:0]  In_Data,
  output logic        In_Ready,
  output logic        Imem_We,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Imem_Wdata,
  output logic        Cpu_Resetn,
  output logic        Done,
  output logic        Error,
  output logic [1:0]  Err_Code,
  output logic [15:0] Words_Written
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t      state, next_state;
  err_t        err_code, err_next;
  logic        accept, timed, timeout, word_last;
  logic [7:0]  len_hi, csum;
  logic [15:0] len, len_rx, words_accepted;
  logic [TW-1:0] idle_cnt;
  logic [31:0] addr;

  assign accept  = In_Valid && In_Ready;
  assign len_rx  = {len_hi, In_Data};
  assign timed   = (state == LEN_LO) || (state == DATA) || (state == CHECK);
  // An accept in the terminal-count cycle wins over the timeout
  assign timeout = timed && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES));

  byte_word_assembler u_asm (
    .clk        (Clock),
    .reset      (Reset),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (In_Data),
    .word_last  (word_last),
    .we         (Imem_We),
    .word       (Imem_Wdata)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= LEN_HI;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_next   = ERR_NONE;
    if (timeout) begin
      next_state = ERROR;
      err_next   = ERR_TIMEOUT;
    end else if (accept) begin
      case (state)
        LEN_HI: next_state = LEN_LO;
        LEN_LO: begin
          if (len_rx > 16'(MAX_WORDS)) begin
            next_state = ERROR;
            err_next   = ERR_LEN;
          end else if (len_rx == 16'd0) begin
            next_state = CHECK;
          end else begin
            next_state = DATA;
          end
        end
        DATA: if (word_last && (words_accepted + 16'd1 == len)) next_state = CHECK;
        CHECK: begin
          if (In_Data == csum) begin
            next_state = DONE;
          end else begin
            next_state = ERROR;
            err_next   = ERR_CSUM;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    In_Ready   = is_loading(state) && !Reset;
    Done       = (state == DONE);
    Error      = (state == ERROR);
    Cpu_Resetn = (state == DONE) && !Reset;
    Err_Code   = err_code;
    Imem_Addr  = addr;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idle_cnt       <= '0;
      csum           <= 8'd0;
      len_hi         <= 8'd0;
      len            <= 16'd0;
      words_accepted <= 16'd0;
      addr           <= BASE_ADDR;
      Words_Written  <= 16'd0;
      err_code       <= ERR_NONE;
    end else begin
      if (accept)     idle_cnt <= '0;
      else if (timed) idle_cnt <= idle_cnt + 1'b1;
      // The CHK byte is compared against the sum, never folded into it
      if (accept && (state != CHECK)) csum <= csum ^ In_Data;
      if (accept && (state == LEN_HI)) len_hi <= In_Data;
      if (accept && (state == LEN_LO)) len <= len_rx;
      if (word_last) words_accepted <= words_accepted + 16'd1;
      if (Imem_We) begin
        addr          <= addr + 32'd4;
        Words_Written <= Words_Written + 16'd1;
      end
      if ((next_state == ERROR) && (state != ERROR)) err_code <= err_next;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        In_Valid = 1'b0;
  logic [7:0]  In_Data = 8'd0;
  logic        In_Ready, Imem_We, Cpu_Resetn, Done, Error;
  logic [31:0] Imem_Addr, Imem_Wdata;
  logic [1:0]  Err_Code;
  logic [15:0] Words_Written;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  frame[$];

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data),
    .In_Ready(In_Ready), .Imem_We(Imem_We), .Imem_Addr(Imem_Addr),
    .Imem_Wdata(Imem_Wdata), .Cpu_Resetn(Cpu_Resetn), .Done(Done),
    .Error(Error), .Err_Code(Err_Code), .Words_Written(Words_Written)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (Imem_We === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", Imem_Addr, Imem_Wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", Imem_Addr, e[63:32]);
        check("write_data", Imem_Wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   waitc;
    logic rdy;
    waitc = 0;
    In_Valid = 1'b1;
    In_Data  = b;
    do begin
      @(negedge Clock);
      rdy = In_Ready;
      @(posedge Clock);
      #1;
      waitc++;
    end while (!rdy && waitc < 50);
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_wait: got In_Ready 0 expected 1 within 50 cycles");
    end
    In_Valid = 1'b0;
    In_Data  = 8'($urandom);
  endtask

  task automatic add_chk(input logic [7:0] bias);
    logic [7:0] x;
    x = 8'd0;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(x ^ bias);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) @(posedge Clock);
        #1;
      end
      send_byte(frame[i]);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic settle_and_check_done(input string tag, input logic [15:0] words);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check({tag, "_done"}, Done, 1);
    check({tag, "_cpu_resetn"}, Cpu_Resetn, 1);
    check({tag, "_error"}, Error, 0);
    check({tag, "_words"}, Words_Written, words);
    check({tag, "_in_ready"}, In_Ready, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_in_ready", In_Ready, 0);
    check("rst_we", Imem_We, 0);
    check("rst_addr", Imem_Addr, 32'h0);
    check("rst_wdata", Imem_Wdata, 32'h0);
    check("rst_cpu_resetn", Cpu_Resetn, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_err_code", Err_Code, 0);
    check("rst_words", Words_Written, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("ready_after_reset", In_Ready, 1);
    @(posedge Clock);
    #1;

    // N=2 back-to-back
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    exp_q.push_back({32'h4, 32'h01234567});
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    add_chk(8'h00);
    check("chk_byte", frame[10], 8'h20);
    send_frame(0);
    settle_and_check_done("n2", 16'd2);
    check("n2_addr", Imem_Addr, 32'h8);

    // CPU reset drops in the cycle Reset is sampled
    Reset = 1'b1;
    @(negedge Clock);
    check("reset_drops_cpu", Cpu_Resetn, 0);
    @(posedge Clock);
    #1;
    do_reset();

    // N=2 with random gaps
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    exp_q.push_back({32'h4, 32'h01234567});
    send_frame(5);
    settle_and_check_done("n2gap", 16'd2);

    // N=0 good checksum
    do_reset();
    frame = '{8'h00, 8'h00};
    add_chk(8'h00);
    send_frame(0);
    settle_and_check_done("n0", 16'd0);

    // N=0 bad checksum
    do_reset();
    frame = '{8'h00, 8'h00, 8'h01};
    send_frame(0);
    @(negedge Clock);
    check("csum_error", Error, 1);
    check("csum_code", Err_Code, 2'b10);
    check("csum_cpu_resetn", Cpu_Resetn, 0);
    check("csum_done", Done, 0);
    @(posedge Clock);
    #1;

    // length too large
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge Clock);
    check("len_error", Error, 1);
    check("len_code", Err_Code, 2'b01);
    check("len_in_ready", In_Ready, 0);
    @(posedge Clock);
    #1;

    // N=256 boundary is accepted (only header sent, then abandoned by reset)
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge Clock);
    check("len_max_ok", Error, 0);
    check("len_max_ready", In_Ready, 1);
    @(posedge Clock);
    #1;

    // timeout after 3 data bytes
    do_reset();
    frame = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send_frame(0);
    begin
      int n;
      n = 0;
      while (Error !== 1'b1 && n < 100) begin
        @(posedge Clock);
        #1;
        n++;
      end
    end
    @(negedge Clock);
    check("to_error", Error, 1);
    check("to_code", Err_Code, 2'b11);
    check("to_words", Words_Written, 0);
    check("to_cpu_resetn", Cpu_Resetn, 0);
    check("to_in_ready", In_Ready, 0);
    @(posedge Clock);
    #1;

    // reset mid-frame, then a fresh N=1 frame
    do_reset();
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
    send_frame(0);
    repeat (2) @(posedge Clock);
    #1;
    check("mid_first_drained", exp_q.size(), 0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("mid_addr", Imem_Addr, 32'h0);
    check("mid_words", Words_Written, 0);
    check("mid_ready", In_Ready, 1);
    @(posedge Clock);
    #1;
    exp_q.push_back({32'h0, 32'hCAFEBABE});
    frame = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    add_chk(8'h00);
    send_frame(2);
    settle_and_check_done("mid_n1", 16'd1);
    check("mid_final_addr", Imem_Addr, 32'h4);

    repeat (3) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
